// File: rtl/beat_scheduler.sv
// beat_scheduler: tempo controller turning a BPM request into a beat period
// and emitting quarter/eighth enables plus a wrapping step index.
module beat_scheduler #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int MIN_BPM     = 30,
    parameter int MAX_BPM     = 240,
    parameter int DEFAULT_BPM = 60,
    parameter int STEPS       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       bpm_load,
    input  logic [7:0] bpm,
    output logic       quarter_en,
    output logic       eighth_en,
    output logic [3:0] step,
    output logic       running,
    output logic       div_busy,
    output logic [7:0] cur_bpm
);

    localparam longint      NUM_L      = longint'(CLK_HZ) * 60;
    localparam logic [31:0] NUM        = 32'(NUM_L);
    localparam logic [31:0] DEF_PERIOD = 32'(NUM_L / DEFAULT_BPM);
    localparam logic [7:0]  MIN_B      = 8'(MIN_BPM);
    localparam logic [7:0]  MAX_B      = 8'(MAX_BPM);
    localparam logic [7:0]  DEF_B      = 8'(DEFAULT_BPM);
    localparam logic [3:0]  LAST_STEP  = 4'(STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] period, period_n;
    logic [3:0]  step_n;
    logic        q_n, e_n;

    logic [7:0]  dvs;
    logic [7:0]  rem, rem_n;
    logic [31:0] quot, quot_n;
    logic [4:0]  div_cnt;
    logic [8:0]  trial;
    logic        ge;
    logic        div_done;
    logic        start;
    logic [7:0]  bpm_c;

    logic        pend_valid;
    logic [31:0] pend_period;
    logic [7:0]  pend_bpm;
    logic        wrap;
    logic        apply;

    // Clamp the request so the divisor is never zero.
    always_comb begin
        bpm_c = bpm;
        if (bpm < MIN_B)
            bpm_c = MIN_B;
        else if (bpm > MAX_B)
            bpm_c = MAX_B;
    end

    // One restoring-division iteration: shift in a numerator bit, subtract if it fits.
    always_comb begin
        trial  = {rem, quot[31]};
        ge     = trial >= {1'b0, dvs};
        rem_n  = ge ? 8'(trial - {1'b0, dvs}) : trial[7:0];
        quot_n = {quot[30:0], ge};
    end

    assign start    = bpm_load && !div_busy;
    assign div_done = div_busy && (div_cnt == 5'd31);

    // Sequential divider; the quotient register starts out holding the numerator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_busy <= 1'b0;
            div_cnt  <= '0;
            dvs      <= '0;
            rem      <= '0;
            quot     <= '0;
        end else if (start) begin
            div_busy <= 1'b1;
            div_cnt  <= '0;
            dvs      <= bpm_c;
            rem      <= '0;
            quot     <= NUM;
        end else if (div_busy) begin
            rem     <= rem_n;
            quot    <= quot_n;
            div_cnt <= div_cnt + 5'd1;
            if (div_done)
                div_busy <= 1'b0;
        end
    end

    assign wrap  = (cnt == period - 32'd1);
    assign apply = pend_valid && ((state == IDLE) || wrap);
    assign period_n = apply ? pend_period : period;

    // Pending result and the tempo in effect; a fresh result beats an apply.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid  <= 1'b0;
            pend_period <= '0;
            pend_bpm    <= '0;
            period      <= DEF_PERIOD;
            cur_bpm     <= DEF_B;
        end else begin
            if (apply) begin
                pend_valid <= 1'b0;
                period     <= pend_period;
                cur_bpm    <= pend_bpm;
            end
            if (div_done) begin
                pend_valid  <= 1'b1;
                pend_period <= quot_n;
                pend_bpm    <= dvs;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic: go is a plain run/stop level.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go)  state_n = RUN;
            RUN:  if (!go) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values of the registered counter and enables.
    always_comb begin
        cnt_n  = '0;
        step_n = '0;
        q_n    = 1'b0;
        e_n    = 1'b0;
        if (state_n == RUN) begin
            if (state == IDLE) begin
                q_n = 1'b1;
                e_n = 1'b1;
            end else begin
                cnt_n  = wrap ? 32'd0 : cnt + 32'd1;
                step_n = step;
                if (wrap)
                    step_n = (step == LAST_STEP) ? 4'd0 : step + 4'd1;
                q_n = wrap;
                e_n = wrap || (cnt_n == (period_n >> 1));
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            step       <= '0;
            quarter_en <= 1'b0;
            eighth_en  <= 1'b0;
            running    <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            step       <= step_n;
            quarter_en <= q_n;
            eighth_en  <= e_n;
            running    <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_beat_scheduler.sv
// tb_beat_scheduler: directed checks of tempo, clamping, divider timing,
// tempo-change boundaries, stop and asynchronous reset.
module tb_beat_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       bpm_load;
    logic [7:0] bpm;
    logic       quarter_en;
    logic       eighth_en;
    logic [3:0] step;
    logic       running;
    logic       div_busy;
    logic [7:0] cur_bpm;

    int errors = 0;
    int checks = 0;
    int e_off;
    int q_off;
    int n;

    beat_scheduler #(
        .CLK_HZ(60), .MIN_BPM(30), .MAX_BPM(240),
        .DEFAULT_BPM(60), .STEPS(16)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .bpm_load(bpm_load), .bpm(bpm),
        .quarter_en(quarter_en), .eighth_en(eighth_en),
        .step(step), .running(running),
        .div_busy(div_busy), .cur_bpm(cur_bpm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Cycles until the first mid-beat eighth and until the next quarter.
    task automatic measure(output int eo, output int qo);
        int k;
        k  = 0;
        eo = -1;
        do begin
            cyc(1);
            k++;
            if (eighth_en && !quarter_en && eo < 0)
                eo = k;
        end while (!quarter_en && k < 2000);
        qo = k;
    endtask

    task automatic load(input logic [7:0] b);
        bpm      = b;
        bpm_load = 1'b1;
        cyc(1);
        bpm_load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; bpm_load = 1'b0; bpm = 8'd0;
        cyc(3);
        chk("rst_quarter", quarter_en, 0);
        chk("rst_eighth", eighth_en, 0);
        chk("rst_step", step, 0);
        chk("rst_running", running, 0);
        chk("rst_busy", div_busy, 0);
        chk("rst_bpm", cur_bpm, 60);

        reset = 1'b1; go = 1'b1;
        cyc(1);
        chk("t1_first_q", quarter_en, 1);
        chk("t1_first_e", eighth_en, 1);
        chk("t1_running", running, 1);
        chk("t1_step0", step, 0);
        measure(e_off, q_off);
        chk("t1_e_off", e_off, 30);
        chk("t1_q_off", q_off, 60);
        chk("t1_step1", step, 1);
        for (int i = 0; i < 14; i++) measure(e_off, q_off);
        chk("t1_step15", step, 15);
        measure(e_off, q_off);
        chk("t1_step_wrap", step, 0);
        chk("t1_q_off_last", q_off, 60);

        cyc(10);
        load(8'd90);
        chk("t3_busy", div_busy, 1);
        measure(e_off, q_off);
        chk("t3_old_e", e_off, 19);
        chk("t3_old_q", q_off, 49);
        chk("t3_bpm", cur_bpm, 90);
        measure(e_off, q_off);
        chk("t3_new_e", e_off, 20);
        chk("t3_new_q", q_off, 40);

        cyc(5);
        go = 1'b0;
        cyc(1);
        chk("t5_stop_run", running, 0);
        chk("t5_stop_step", step, 0);
        chk("t5_stop_q", quarter_en, 0);
        chk("t5_stop_e", eighth_en, 0);

        load(8'd120);
        n = 0;
        while (div_busy && n < 100) begin
            n++;
            cyc(1);
        end
        chk("t2_busy_len", n, 32);
        chk("t2_bpm_hold", cur_bpm, 90);
        cyc(1);
        chk("t2_bpm_new", cur_bpm, 120);
        go = 1'b1;
        cyc(1);
        chk("t2_first_q", quarter_en, 1);
        measure(e_off, q_off);
        chk("t2_e", e_off, 15);
        chk("t2_q", q_off, 30);

        go = 1'b0;
        cyc(1);
        load(8'd0);
        cyc(33);
        chk("t4_lo_bpm", cur_bpm, 30);
        go = 1'b1;
        cyc(1);
        measure(e_off, q_off);
        chk("t4_lo_e", e_off, 60);
        chk("t4_lo_q", q_off, 120);

        go = 1'b0;
        cyc(1);
        load(8'd255);
        cyc(33);
        chk("t4_hi_bpm", cur_bpm, 240);
        go = 1'b1;
        cyc(1);
        measure(e_off, q_off);
        chk("t4_hi_e", e_off, 7);
        chk("t4_hi_q", q_off, 15);

        go = 1'b0;
        cyc(1);
        load(8'd200);
        cyc(5);
        load(8'd100);
        cyc(40);
        chk("t5_ignore_bpm", cur_bpm, 200);
        go = 1'b1;
        cyc(1);
        measure(e_off, q_off);
        chk("t5_ignore_e", e_off, 9);
        chk("t5_ignore_q", q_off, 18);

        cyc(3);
        load(8'd150);
        cyc(5);
        chk("t6_busy_pre", div_busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_q", quarter_en, 0);
        chk("t6_e", eighth_en, 0);
        chk("t6_step", step, 0);
        chk("t6_running", running, 0);
        chk("t6_busy", div_busy, 0);
        chk("t6_bpm", cur_bpm, 60);
        go = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(50);
        chk("t6_no_pend", cur_bpm, 60);
        go = 1'b1;
        cyc(1);
        measure(e_off, q_off);
        chk("t6_q_off", q_off, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
